// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter (+ helper mem_port_arbiter_fifo)
//  Purpose  : Shares one valid/ready memory port between icache line reads,
//             dcache line reads and dcache dirty-line writebacks. Request
//             pulses are buffered per source, arbitrated (writeback strict
//             priority, round-robin between reads) into a registered request
//             slot, and in-order read responses are routed back to the
//             requester using a FIFO of source tags.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             ic_req_* / dc_req_*             request pulses from the L1s
//             ic_rec_* / dc_rec_*             1-cycle refill strobes + data
//             mem_req_* / mem_rsp_*           memory request/response channel
//             err_overflow, err_orphan_rsp    sticky error flags
//  Revision : 1.0  initial release
// ============================================================================

// Simple FIFO with first-word fall-through read data. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mem_port_arbiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int RD_DEPTH = 4,
  parameter int WB_DEPTH = 2,
  parameter int MAX_OUT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_ren,
  input  logic [ADDR_W-1:0] ic_req_raddr,
  input  logic              dc_req_ren,
  input  logic [ADDR_W-1:0] dc_req_raddr,
  input  logic              dc_req_wen,
  input  logic [ADDR_W-1:0] dc_req_waddr,
  input  logic [LINE_W-1:0] dc_req_wcacheline,
  output logic              ic_rec_en,
  output logic [ADDR_W-1:0] ic_rec_addr,
  output logic [LINE_W-1:0] ic_rec_cacheline,
  output logic              dc_rec_en,
  output logic [ADDR_W-1:0] dc_rec_addr,
  output logic [LINE_W-1:0] dc_rec_cacheline,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [ADDR_W-1:0] mem_rsp_addr,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              err_overflow,
  output logic              err_orphan_rsp
);
  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  logic [ADDR_W-1:0]        ic_head;
  logic [ADDR_W-1:0]        dc_head;
  logic [ADDR_W+LINE_W-1:0] wb_head;
  logic [0:0]               tag_head;
  logic ic_empty, ic_full, dc_empty, dc_full, wb_empty, wb_full;
  logic tag_empty, tag_full;
  logic load;
  logic read_ok;
  logic sel_ic, sel_dc, sel_wb;
  logic tag_push;
  logic rsp_hit;
  logic pref_dc;   // round-robin pointer: 1 = dcache preferred next

  // The request slot may be (re)loaded when empty or when it hands off now.
  assign load = !mem_req_valid || mem_req_ready;

  // A read may be loaded if the tag FIFO has room, counting a slot freed by
  // a response popping in this same cycle.
  assign read_ok = !tag_full || mem_rsp_valid;

  always_comb begin
    sel_wb = 1'b0;
    sel_ic = 1'b0;
    sel_dc = 1'b0;
    if (load) begin
      if (!wb_empty) begin
        sel_wb = 1'b1;
      end else if (read_ok) begin
        if (!ic_empty && (dc_empty || !pref_dc)) begin
          sel_ic = 1'b1;
        end else if (!dc_empty) begin
          sel_dc = 1'b1;
        end
      end
    end
  end

  assign tag_push = sel_ic || sel_dc;
  assign rsp_hit  = mem_rsp_valid && !tag_empty;

  mem_port_arbiter_fifo #(.WIDTH(ADDR_W), .DEPTH(RD_DEPTH)) u_ic_fifo (
    .clk(clk), .rst_n(rst_n), .push(ic_req_ren), .wdata(ic_req_raddr),
    .pop(sel_ic), .rdata(ic_head), .empty(ic_empty), .full(ic_full)
  );

  mem_port_arbiter_fifo #(.WIDTH(ADDR_W), .DEPTH(RD_DEPTH)) u_dc_fifo (
    .clk(clk), .rst_n(rst_n), .push(dc_req_ren), .wdata(dc_req_raddr),
    .pop(sel_dc), .rdata(dc_head), .empty(dc_empty), .full(dc_full)
  );

  mem_port_arbiter_fifo #(.WIDTH(ADDR_W + LINE_W), .DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk(clk), .rst_n(rst_n), .push(dc_req_wen),
    .wdata({dc_req_waddr, dc_req_wcacheline}),
    .pop(sel_wb), .rdata(wb_head), .empty(wb_empty), .full(wb_full)
  );

  mem_port_arbiter_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk(clk), .rst_n(rst_n), .push(tag_push), .wdata(sel_dc),
    .pop(mem_rsp_valid), .rdata(tag_head), .empty(tag_empty), .full(tag_full)
  );

  // Request slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      pref_dc       <= 1'b0;
    end else if (load) begin
      mem_req_valid <= sel_wb || sel_ic || sel_dc;
      if (sel_wb) begin
        mem_req_write <= 1'b1;
        mem_req_addr  <= wb_head[ADDR_W+LINE_W-1:LINE_W];
        mem_req_wdata <= wb_head[LINE_W-1:0];
      end else if (sel_ic) begin
        mem_req_write <= 1'b0;
        mem_req_addr  <= ic_head;
        pref_dc       <= 1'b1;
      end else if (sel_dc) begin
        mem_req_write <= 1'b0;
        mem_req_addr  <= dc_head;
        pref_dc       <= 1'b0;
      end
    end
  end

  // Response routing: the tag at the head says which cache gets the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_rec_en        <= 1'b0;
      ic_rec_addr      <= '0;
      ic_rec_cacheline <= '0;
      dc_rec_en        <= 1'b0;
      dc_rec_addr      <= '0;
      dc_rec_cacheline <= '0;
    end else begin
      ic_rec_en <= rsp_hit && (tag_head[0] == SRC_IC);
      dc_rec_en <= rsp_hit && (tag_head[0] == SRC_DC);
      if (rsp_hit && (tag_head[0] == SRC_IC)) begin
        ic_rec_addr      <= mem_rsp_addr;
        ic_rec_cacheline <= mem_rsp_data;
      end
      if (rsp_hit && (tag_head[0] == SRC_DC)) begin
        dc_rec_addr      <= mem_rsp_addr;
        dc_rec_cacheline <= mem_rsp_data;
      end
    end
  end

  // Sticky error flags. A full FIFO being popped this cycle still accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow   <= 1'b0;
      err_orphan_rsp <= 1'b0;
    end else begin
      if ((ic_req_ren && ic_full && !sel_ic) ||
          (dc_req_ren && dc_full && !sel_dc) ||
          (dc_req_wen && wb_full && !sel_wb)) begin
        err_overflow <= 1'b1;
      end
      if (mem_rsp_valid && tag_empty) begin
        err_orphan_rsp <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ic_req_ren;
  logic [ADDR_W-1:0] ic_req_raddr;
  logic              dc_req_ren;
  logic [ADDR_W-1:0] dc_req_raddr;
  logic              dc_req_wen;
  logic [ADDR_W-1:0] dc_req_waddr;
  logic [LINE_W-1:0] dc_req_wcacheline;
  logic              ic_rec_en;
  logic [ADDR_W-1:0] ic_rec_addr;
  logic [LINE_W-1:0] ic_rec_cacheline;
  logic              dc_rec_en;
  logic [ADDR_W-1:0] dc_rec_addr;
  logic [LINE_W-1:0] dc_rec_cacheline;
  logic              mem_req_valid;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [ADDR_W-1:0] mem_rsp_addr;
  logic [LINE_W-1:0] mem_rsp_data;
  logic              err_overflow;
  logic              err_orphan_rsp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_ren(ic_req_ren), .ic_req_raddr(ic_req_raddr),
    .dc_req_ren(dc_req_ren), .dc_req_raddr(dc_req_raddr),
    .dc_req_wen(dc_req_wen), .dc_req_waddr(dc_req_waddr),
    .dc_req_wcacheline(dc_req_wcacheline),
    .ic_rec_en(ic_rec_en), .ic_rec_addr(ic_rec_addr), .ic_rec_cacheline(ic_rec_cacheline),
    .dc_rec_en(dc_rec_en), .dc_rec_addr(dc_rec_addr), .dc_rec_cacheline(dc_rec_cacheline),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
    .err_overflow(err_overflow), .err_orphan_rsp(err_orphan_rsp)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ic_req_ren = 0; ic_req_raddr = '0;
    dc_req_ren = 0; dc_req_raddr = '0;
    dc_req_wen = 0; dc_req_waddr = '0; dc_req_wcacheline = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_addr = '0; mem_rsp_data = '0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    apply_reset();
    got = {mem_req_valid, mem_req_write, ic_rec_en, dc_rec_en,
           err_overflow, err_orphan_rsp, 2'b00};
    total++;
    if (got !== 8'h00) begin
      bad++; $display("FAIL reset_flags got=%h want=00", got);
    end
    total++;
    if (mem_req_addr !== 32'h0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", mem_req_addr);
    end
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] d;
    d = {4{32'hAAAAAAAA}};
    apply_reset();
    mem_req_ready = 1;
    ic_req_ren = 1; ic_req_raddr = 32'h100;
    tick();
    ic_req_ren = 0;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL single_cycle1_valid got=%b want=0", mem_req_valid);
    end
    tick();
    total++;
    if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL single_issue got v=%b w=%b a=%h want v=1 w=0 a=100",
                      mem_req_valid, mem_req_write, mem_req_addr);
    end
    tick();
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL single_after_hs got=%b want=0", mem_req_valid);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h100; mem_rsp_data = d;
    tick();
    mem_rsp_valid = 0;
    total++;
    if ({ic_rec_en, dc_rec_en, ic_rec_addr} !== {1'b1, 1'b0, 32'h100} || ic_rec_cacheline !== d) begin
      bad++; $display("FAIL single_refill got ic=%b dc=%b a=%h d=%h want ic=1 dc=0 a=100 d=%h",
                      ic_rec_en, dc_rec_en, ic_rec_addr, ic_rec_cacheline, d);
    end
    tick();
    total++;
    if ({ic_rec_en, dc_rec_en} !== 2'b00) begin
      bad++; $display("FAIL single_refill_1cyc got=%b%b want=00", ic_rec_en, dc_rec_en);
    end
  endtask

  task automatic test_two_reads();
    logic [LINE_W-1:0] da, db;
    da = {4{32'h11111111}};
    db = {4{32'h22222222}};
    apply_reset();
    mem_req_ready = 1;
    ic_req_ren = 1; ic_req_raddr = 32'h100;
    dc_req_ren = 1; dc_req_raddr = 32'h200;
    tick();
    ic_req_ren = 0; dc_req_ren = 0;
    tick();
    total++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL two_first got v=%b a=%h want v=1 a=100", mem_req_valid, mem_req_addr);
    end
    tick();
    total++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h200}) begin
      bad++; $display("FAIL two_second got v=%b a=%h want v=1 a=200", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_rsp_valid = 1; mem_rsp_addr = 32'h100; mem_rsp_data = da;
    tick();
    mem_rsp_addr = 32'h200; mem_rsp_data = db;
    total++;
    if ({ic_rec_en, dc_rec_en, ic_rec_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL two_rsp_ic got ic=%b dc=%b a=%h want ic=1 dc=0 a=100",
                      ic_rec_en, dc_rec_en, ic_rec_addr);
    end
    tick();
    mem_rsp_valid = 0;
    total++;
    if ({ic_rec_en, dc_rec_en, dc_rec_addr, ic_rec_addr} !== {1'b0, 1'b1, 32'h200, 32'h100} ||
        dc_rec_cacheline !== db) begin
      bad++; $display("FAIL two_rsp_dc got ic=%b dc=%b da=%h ia=%h want ic=0 dc=1 da=200 ia=100",
                      ic_rec_en, dc_rec_en, dc_rec_addr, ic_rec_addr);
    end
  endtask

  task automatic test_wb_priority();
    logic [LINE_W-1:0] w;
    w = {4{32'hC0FFEE00}};
    apply_reset();
    mem_req_ready = 1;
    dc_req_ren = 1; dc_req_raddr = 32'h300;
    dc_req_wen = 1; dc_req_waddr = 32'h400; dc_req_wcacheline = w;
    tick();
    dc_req_ren = 0; dc_req_wen = 0;
    tick();
    total++;
    if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b1, 32'h400} || mem_req_wdata !== w) begin
      bad++; $display("FAIL wb_first got v=%b w=%b a=%h d=%h want v=1 w=1 a=400 d=%h",
                      mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, w);
    end
    tick();
    total++;
    if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 32'h300}) begin
      bad++; $display("FAIL wb_then_read got v=%b w=%b a=%h want v=1 w=0 a=300",
                      mem_req_valid, mem_req_write, mem_req_addr);
    end
  endtask

  task automatic test_stall_overflow();
    logic [ADDR_W-1:0] exp_seq [5];
    exp_seq[0] = 32'h500; exp_seq[1] = 32'h10; exp_seq[2] = 32'h20;
    exp_seq[3] = 32'h30;  exp_seq[4] = 32'h40;
    apply_reset();
    mem_req_ready = 0;
    ic_req_ren = 1; ic_req_raddr = 32'h500;
    tick();
    ic_req_ren = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      dc_req_ren = 1; dc_req_raddr = ADDR_W'((i + 1) * 16);
      tick();
      dc_req_ren = 0;
      total++;
      if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 32'h500}) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b a=%h want v=1 a=500", i, mem_req_valid, mem_req_addr);
      end
      total++;
      if (err_overflow !== (i == 4)) begin
        bad++; $display("FAIL stall_ovf[%0d] got=%b want=%b", i, err_overflow, (i == 4));
      end
    end
    mem_req_ready = 1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({mem_req_valid, mem_req_addr} !== {1'b1, exp_seq[k]}) begin
        bad++; $display("FAIL drain[%0d] got v=%b a=%h want v=1 a=%h", k, mem_req_valid, mem_req_addr, exp_seq[k]);
      end
      tick();
    end
    total++;
    if ({mem_req_valid, err_overflow} !== 2'b01) begin
      bad++; $display("FAIL drain_end got v=%b ovf=%b want v=0 ovf=1", mem_req_valid, err_overflow);
    end
  endtask

  task automatic test_max_out();
    int issued;
    logic [ADDR_W-1:0] last_addr;
    logic found;
    apply_reset();
    mem_req_ready = 1;
    issued = 0;
    last_addr = '0;
    for (int c = 0; c < 40; c++) begin
      if (c < 9) begin
        if (c % 2 == 0) begin ic_req_ren = 1; ic_req_raddr = ADDR_W'(32'h1000 + c * 16); end
        else            begin dc_req_ren = 1; dc_req_raddr = ADDR_W'(32'h1000 + c * 16); end
      end
      if (mem_req_valid && mem_req_ready) begin
        issued++;
        last_addr = mem_req_addr;
      end
      tick();
      ic_req_ren = 0; dc_req_ren = 0;
    end
    total++;
    if (issued !== 8 || last_addr !== 32'h1070) begin
      bad++; $display("FAIL maxout_issued got n=%0d last=%h want n=8 last=1070", issued, last_addr);
    end
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL maxout_held got v=%b want 0", mem_req_valid);
    end
    dc_req_wen = 1; dc_req_waddr = 32'hF00; dc_req_wcacheline = {4{32'h5A5A5A5A}};
    tick();
    dc_req_wen = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (mem_req_valid && mem_req_write && mem_req_addr == 32'hF00) found = 1;
      else tick();
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL maxout_wb got found=%b want 1", found);
    end
    mem_rsp_valid = 1; mem_rsp_addr = 32'h1000; mem_rsp_data = {4{32'h33333333}};
    tick();
    mem_rsp_valid = 0;
    total++;
    if ({ic_rec_en, dc_rec_en, ic_rec_addr} !== {1'b1, 1'b0, 32'h1000}) begin
      bad++; $display("FAIL maxout_rsp got ic=%b dc=%b a=%h want ic=1 dc=0 a=1000",
                      ic_rec_en, dc_rec_en, ic_rec_addr);
    end
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (mem_req_valid && !mem_req_write) found = 1;
      else tick();
    end
    total++;
    if (found !== 1'b1 || mem_req_addr !== 32'h1080) begin
      bad++; $display("FAIL maxout_ninth got found=%b a=%h want found=1 a=1080", found, mem_req_addr);
    end
  endtask

  task automatic test_orphan();
    // Reads from the previous test are still in flight; reset forgets them.
    apply_reset();
    mem_rsp_valid = 1; mem_rsp_addr = 32'h1010; mem_rsp_data = {4{32'h44444444}};
    tick();
    mem_rsp_valid = 0;
    total++;
    if ({ic_rec_en, dc_rec_en, err_orphan_rsp} !== 3'b001) begin
      bad++; $display("FAIL orphan got ic=%b dc=%b err=%b want ic=0 dc=0 err=1",
                      ic_rec_en, dc_rec_en, err_orphan_rsp);
    end
    tick();
    total++;
    if (err_orphan_rsp !== 1'b1) begin
      bad++; $display("FAIL orphan_sticky got=%b want=1", err_orphan_rsp);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] exp_seq [4];
    exp_seq[0] = 32'h2000; exp_seq[1] = 32'h3000;
    exp_seq[2] = 32'h2010; exp_seq[3] = 32'h3010;
    apply_reset();
    mem_req_ready = 1;
    ic_req_ren = 1; ic_req_raddr = 32'h2000; dc_req_ren = 1; dc_req_raddr = 32'h3000;
    tick();
    ic_req_raddr = 32'h2010; dc_req_raddr = 32'h3010;
    tick();
    ic_req_ren = 0; dc_req_ren = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({mem_req_valid, mem_req_addr} !== {1'b1, exp_seq[k]}) begin
        bad++; $display("FAIL b2b[%0d] got v=%b a=%h want v=1 a=%h", k, mem_req_valid, mem_req_addr, exp_seq[k]);
      end
      tick();
    end
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got v=%b want 0", mem_req_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_two_reads();
    test_wb_priority();
    test_stall_overflow();
    test_max_out();
    test_orphan();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
